// File: rtl/odo_pkg.sv
// Shared BCD definitions for the odometer / trip meter block.
package odo_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    // Single-digit increment: returns {carry_out, next_digit}. Out-of-range codes roll to 0.
    function automatic logic [BCD_W:0] bcd_inc(input logic [BCD_W-1:0] value);
        if (value >= BCD_MAX) begin
            return {1'b1, {BCD_W{1'b0}}};
        end
        return {1'b0, value + BCD_W'(1)};
    endfunction

endpackage

// File: rtl/odometer_trip_if.sv
// Distance-pulse / button inputs and meter / display outputs of odometer_trip.
interface odometer_trip_if #(
    parameter int DIGITS = 4
) ();

    logic                  dist_pulse;
    logic                  btn_trip_clr;
    logic                  btn_disp_sel;
    logic [4*DIGITS-1:0]   odo_bcd;
    logic [4*DIGITS-1:0]   trip_bcd;
    logic [4*DIGITS-1:0]   disp_bcd;
    logic                  disp_sel;
    logic                  odo_wrap;

    modport master (
        output dist_pulse,
        output btn_trip_clr,
        output btn_disp_sel,
        input  odo_bcd,
        input  trip_bcd,
        input  disp_bcd,
        input  disp_sel,
        input  odo_wrap
    );

    modport slave (
        input  dist_pulse,
        input  btn_trip_clr,
        input  btn_disp_sel,
        output odo_bcd,
        output trip_bcd,
        output disp_bcd,
        output disp_sel,
        output odo_wrap
    );

endinterface

// File: rtl/btn_debounce.sv
// Raw push-button conditioning: synchroniser, level debouncer and a one-cycle
// registered pulse on each accepted press.
module btn_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_level_d;
    logic                   r_press;
    logic                   w_sync_out;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    if (SYNC_STAGES > 1) begin : g_chain
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
            end
        end
    end else begin : g_single
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync <= '0;
            end else begin
                r_sync <= i_btn;
            end
        end
    end

    // The level only moves after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            if (w_sync_out == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= w_sync_out;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/odometer_trip.sv
// BCD odometer with sticky wrap flag, clearable trip meter and a
// button-selected display mux, all fed by the 0.1 km distance pulse.
module odometer_trip
    import odo_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 250000
) (
    input  logic           clk,
    input  logic           rst_n,
    odometer_trip_if.slave bus
);

    localparam int MW = BCD_W * DIGITS;
    localparam logic [MW-1:0] ALL_NINES = {DIGITS{BCD_MAX}};

    logic [MW-1:0] r_odo;
    logic [MW-1:0] r_trip;
    logic          r_wrap;
    logic          r_sel;
    logic [MW-1:0] w_odo_next;
    logic [MW-1:0] w_trip_next;
    logic          w_odo_rollover;
    logic          w_clr_press;
    logic          w_sel_press;

    // Ripple the carry through every digit in one cycle; the top carry is dropped.
    function automatic logic [MW-1:0] meter_inc(input logic [MW-1:0] value);
        logic [MW-1:0]    res;
        logic [BCD_W:0]   dig;
        logic             carry;
        res   = value;
        carry = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (carry) begin
                dig = bcd_inc(value[d*BCD_W +: BCD_W]);
                res[d*BCD_W +: BCD_W] = dig[BCD_W-1:0];
                carry = dig[BCD_W];
            end
        end
        return res;
    endfunction

    assign w_odo_next     = meter_inc(r_odo);
    assign w_trip_next    = meter_inc(r_trip);
    assign w_odo_rollover = bus.dist_pulse && (r_odo == ALL_NINES);

    btn_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYCLES  (DEB_CYCLES)
    ) u_trip_clr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (bus.btn_trip_clr),
        .o_press (w_clr_press)
    );

    btn_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYCLES  (DEB_CYCLES)
    ) u_disp_sel (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (bus.btn_disp_sel),
        .o_press (w_sel_press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_odo  <= '0;
            r_trip <= '0;
            r_wrap <= 1'b0;
            r_sel  <= 1'b0;
        end else begin
            if (bus.dist_pulse) begin
                r_odo <= w_odo_next;
            end
            if (w_odo_rollover) begin
                r_wrap <= 1'b1;
            end
            // A clear landing with a distance pulse leaves the trip at zero.
            if (w_clr_press) begin
                r_trip <= '0;
            end else if (bus.dist_pulse) begin
                r_trip <= w_trip_next;
            end
            if (w_sel_press) begin
                r_sel <= ~r_sel;
            end
        end
    end

    assign bus.odo_bcd  = r_odo;
    assign bus.trip_bcd = r_trip;
    assign bus.odo_wrap = r_wrap;
    assign bus.disp_sel = r_sel;
    assign bus.disp_bcd = r_sel ? r_trip : r_odo;

endmodule

// File: tb/tb_odometer_trip.sv
// Directed vector bench for odometer_trip with a short debounce window.
module tb_odometer_trip;

    logic clk;
    logic rst_n;

    int n_vec;
    int n_bad;

    odometer_trip_if #(.DIGITS(4)) bus ();

    odometer_trip #(
        .DIGITS      (4),
        .SYNC_STAGES (2),
        .DEB_CYCLES  (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pulse;
        logic        tclr;
        logic        dsel;
        logic [15:0] e_odo;
        logic [15:0] e_trip;
        logic        e_sel;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        int v;
        v = n;
        r = '0;
        for (int d = 0; d < 4; d++) begin
            r[d*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic add(input logic p, input logic tc, input logic ds,
                       input logic [15:0] eo, input logic [15:0] et, input logic es);
        vec_t v;
        v.pulse  = p;
        v.tclr   = tc;
        v.dsel   = ds;
        v.e_odo  = eo;
        v.e_trip = et;
        v.e_sel  = es;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic step(input logic p, input logic tc, input logic ds);
        bus.dist_pulse   = p;
        bus.btn_trip_clr = tc;
        bus.btn_disp_sel = ds;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.dist_pulse   = 1'b0;
        bus.btn_trip_clr = 1'b0;
        bus.btn_disp_sel = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic [15:0] eo, input logic [15:0] et,
                           input logic es, input logic ew);
        chk({tag, " odo"},  bus.odo_bcd,  eo);
        chk({tag, " trip"}, bus.trip_bcd, et);
        chk({tag, " sel"},  16'(bus.disp_sel), 16'(es));
        chk({tag, " wrap"}, 16'(bus.odo_wrap), 16'(ew));
        chk({tag, " disp"}, bus.disp_bcd, es ? et : eo);
    endtask

    initial begin
        int n;
        int cyc;
        logic p;

        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.dist_pulse   = 1'b0;
        bus.btn_trip_clr = 1'b0;
        bus.btn_disp_sel = 1'b0;

        // Ten isolated pulses, then back-to-back up to 123.
        for (int i = 1; i <= 10; i++) begin
            add(1'b1, 1'b0, 1'b0, to_bcd(i), to_bcd(i), 1'b0);
            add(1'b0, 1'b0, 1'b0, to_bcd(i), to_bcd(i), 1'b0);
        end
        for (int i = 11; i <= 123; i++) add(1'b1, 1'b0, 1'b0, to_bcd(i), to_bcd(i), 1'b0);
        // Trip clear held 10 cycles: takes effect on the 8th edge; pulses after it must count.
        for (int i = 1; i <= 7; i++) add(1'b0, 1'b1, 1'b0, 16'h0123, 16'h0123, 1'b0);
        add(1'b0, 1'b1, 1'b0, 16'h0123, 16'h0000, 1'b0);
        add(1'b1, 1'b1, 1'b0, 16'h0124, 16'h0001, 1'b0);
        add(1'b1, 1'b1, 1'b0, 16'h0125, 16'h0002, 1'b0);
        for (int i = 0; i < 12; i++) add(1'b0, 1'b0, 1'b0, 16'h0125, 16'h0002, 1'b0);
        // 3-cycle glitch and 1,0,1,1,0 bounce must not clear.
        for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b0, 16'h0125, 16'h0002, 1'b0);
        for (int i = 0; i < 12; i++) add(1'b0, 1'b0, 1'b0, 16'h0125, 16'h0002, 1'b0);
        add(1'b0, 1'b1, 1'b0, 16'h0125, 16'h0002, 1'b0);
        add(1'b0, 1'b0, 1'b0, 16'h0125, 16'h0002, 1'b0);
        add(1'b0, 1'b1, 1'b0, 16'h0125, 16'h0002, 1'b0);
        add(1'b0, 1'b1, 1'b0, 16'h0125, 16'h0002, 1'b0);
        for (int i = 0; i < 13; i++) add(1'b0, 1'b0, 1'b0, 16'h0125, 16'h0002, 1'b0);
        // Two display-select presses.
        for (int i = 1; i <= 10; i++) add(1'b0, 1'b0, 1'b1, 16'h0125, 16'h0002, i >= 8);
        for (int i = 0; i < 12; i++) add(1'b0, 1'b0, 1'b0, 16'h0125, 16'h0002, 1'b1);
        for (int i = 1; i <= 10; i++) add(1'b0, 1'b0, 1'b1, 16'h0125, 16'h0002, i < 8);
        for (int i = 0; i < 12; i++) add(1'b0, 1'b0, 1'b0, 16'h0125, 16'h0002, 1'b0);

        do_reset();
        chk_all("reset", 16'h0000, 16'h0000, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            step(tbl[i].pulse, tbl[i].tclr, tbl[i].dsel);
            chk_all($sformatf("vec%0d", i), tbl[i].e_odo, tbl[i].e_trip, tbl[i].e_sel, 1'b0);
        end

        // Select the trip view, then reset in the middle of a second press.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0);
        chk_all("sel_on", 16'h0125, 16'h0002, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        chk_all("mid_deb", 16'h0125, 16'h0002, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 16'h0000, 16'h0000, 1'b0, 1'b0);
        bus.btn_disp_sel = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0);
        chk_all("post_rst", 16'h0000, 16'h0000, 1'b0, 1'b0);

        // Clear effect edge coincides with a distance pulse.
        for (int i = 0; i < 42; i++) step(1'b1, 1'b0, 1'b0);
        chk_all("pre_coinc", 16'h0042, 16'h0042, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0);
        chk_all("coinc_m1", 16'h0042, 16'h0042, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk_all("coinc", 16'h0043, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0);
        chk_all("coinc_after", 16'h0043, 16'h0000, 1'b0, 1'b0);

        // Full range with bursts of back-to-back pulses, then the rollover.
        do_reset();
        n = 0;
        cyc = 0;
        while (n < 9999) begin
            p = ((cyc % 7) != 6);
            step(p, 1'b0, 1'b0);
            if (p) begin
                n++;
                if ((n % 1000) == 0) chk($sformatf("odo_%0d", n), bus.odo_bcd, to_bcd(n));
            end
            cyc++;
        end
        chk_all("at_9999", 16'h9999, 16'h9999, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk_all("wrap", 16'h0000, 16'h0000, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk_all("after_wrap", 16'h0001, 16'h0001, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
        chk_all("wrap_sticky", 16'h0001, 16'h0001, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
